// File: rtl/sevseg_mux_n.sv
// N-digit time-multiplexed seven-segment driver with a registered nibble-sum output.
// Optional macro BLANK_GAP_EN inserts BLANK_CYC dead cycles at the start of every digit slot.
//
// state   | meaning
// S_BLANK | all anodes and segments inactive (dead time between digits)
// S_SHOW  | anode[r_idx] active, segments decode the held nibble for r_idx
module sevseg_mux_n #(
  parameter int NDIGITS     = 2,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [4*NDIGITS-1:0]         digits,
  input  logic                         load,
  output logic [6:0]                   seg,
  output logic [NDIGITS-1:0]           anode,
  output logic [3+$clog2(NDIGITS):0]   sum,
  output logic                         slot_tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NDIGITS);
  localparam int SW = 4 + IW;

  localparam logic [CW-1:0]      CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]      BLANK_END = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0]      IDX_MAX   = IW'(NDIGITS - 1);
  localparam logic [NDIGITS-1:0] ONE_HOT0  = NDIGITS'(1);
  localparam logic [6:0]         SEG_OFF   = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NDIGITS-1:0] AN_OFF    = (ACTIVE_LOW != 0) ? '1 : '0;

`ifdef BLANK_GAP_EN
  localparam logic BLANK_EN = 1'b1;
`else
  localparam logic BLANK_EN = 1'b0;
`endif

  typedef enum logic {S_BLANK, S_SHOW} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [4*NDIGITS-1:0] r_held;
  logic [SW-1:0]        r_sum;
  logic                 r_tick;
  logic                 r_run;
  logic [6:0]           r_seg;
  logic [NDIGITS-1:0]   r_anode;

  logic                 w_wrap;
  logic                 w_blank_end;
  logic [3:0]           w_nib;
  logic [SW-1:0]        w_sum;
  logic [6:0]           w_seg_ah;
  logic [NDIGITS-1:0]   w_anode_ah;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b0111111;
      4'h1: hex7 = 7'b0000110;
      4'h2: hex7 = 7'b1011011;
      4'h3: hex7 = 7'b1001111;
      4'h4: hex7 = 7'b1100110;
      4'h5: hex7 = 7'b1101101;
      4'h6: hex7 = 7'b1111101;
      4'h7: hex7 = 7'b0000111;
      4'h8: hex7 = 7'b1111111;
      4'h9: hex7 = 7'b1101111;
      4'hA: hex7 = 7'b1110111;
      4'hB: hex7 = 7'b1111100;
      4'hC: hex7 = 7'b0111001;
      4'hD: hex7 = 7'b1011110;
      4'hE: hex7 = 7'b1111001;
      default: hex7 = 7'b1110001;
    endcase
  endfunction

  assign w_wrap      = (r_cnt == CNT_MAX);
  assign w_blank_end = (r_cnt == BLANK_END);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_tick <= 1'b0;
      r_run  <= 1'b0;
    end else begin
      r_run  <= 1'b1;
      r_tick <= w_wrap;
      r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
      // Explicit wrap keeps non-power-of-2 digit counts off unused index codes.
      if (w_wrap) r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= BLANK_EN ? S_BLANK : S_SHOW;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BLANK: if (w_blank_end) w_state_nxt = S_SHOW;
      default: w_state_nxt = r_state;
    endcase
    if (w_wrap) w_state_nxt = BLANK_EN ? S_BLANK : S_SHOW;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_held <= '0;
      r_sum  <= '0;
    end else begin
      if (load) r_held <= digits;
      r_sum <= w_sum;
    end
  end

  always_comb begin
    w_sum = '0;
    w_nib = r_held[3:0];
    for (int k = 0; k < NDIGITS; k++) begin
      w_sum = w_sum + SW'(r_held[4*k +: 4]);
      if (r_idx == IW'(k)) w_nib = r_held[4*k +: 4];
    end
  end

  // r_run holds the outputs dark for the first edge after reset so anode[0] lights on the second.
  always_comb begin
    w_seg_ah   = '0;
    w_anode_ah = '0;
    if (r_run && (r_state == S_SHOW)) begin
      w_seg_ah   = hex7(w_nib);
      w_anode_ah = ONE_HOT0 << r_idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg   <= SEG_OFF;
      r_anode <= AN_OFF;
    end else begin
      r_seg   <= (ACTIVE_LOW != 0) ? ~w_seg_ah : w_seg_ah;
      r_anode <= (ACTIVE_LOW != 0) ? ~w_anode_ah : w_anode_ah;
    end
  end

  assign seg       = r_seg;
  assign anode     = r_anode;
  assign sum       = r_sum;
  assign slot_tick = r_tick;

endmodule

// File: tb/tb_sevseg_mux_n.sv
// Directed bench for sevseg_mux_n: 2-digit and 3-digit instances with REFRESH_DIV=4, plus a
// BLANK_CYC=2 instance whose expected pattern depends on whether BLANK_GAP_EN is defined.
module tb_sevseg_mux_n;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [7:0]  digits = '0;
  logic [11:0] digits3 = '0;

  logic [6:0]  seg, seg3, seg_b;
  logic [1:0]  anode, anode_b;
  logic [2:0]  anode3;
  logic [4:0]  sum, sum_b;
  logic [5:0]  sum3;
  logic        slot_tick, tick3, tick_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sevseg_mux_n #(.NDIGITS(2), .REFRESH_DIV(4), .BLANK_CYC(2), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .digits(digits), .load(load),
    .seg(seg), .anode(anode), .sum(sum), .slot_tick(slot_tick));

  sevseg_mux_n #(.NDIGITS(3), .REFRESH_DIV(4), .BLANK_CYC(2), .ACTIVE_LOW(1)) dut3 (
    .clk(clk), .reset(reset), .digits(digits3), .load(load),
    .seg(seg3), .anode(anode3), .sum(sum3), .slot_tick(tick3));

  sevseg_mux_n #(.NDIGITS(2), .REFRESH_DIV(4), .BLANK_CYC(2), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .reset(reset), .digits(digits), .load(load),
    .seg(seg_b), .anode(anode_b), .sum(sum_b), .slot_tick(tick_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] exp3;
    logic [1:0] exp_an;
    logic [6:0] exp_seg;
    int d, prev;
    bit show;

    // reset held across clock edges
    step(); step();
    check("rst_seg", seg, 7'h7F);
    check("rst_anode", anode, 2'b11);
    check("rst_sum", sum, 0);
    check("rst_tick", slot_tick, 0);

    reset = 1'b0;
    step();
    check("run1_anode", anode, 2'b11);
    step();
    check("run2_anode", anode, 2'b10);
    check("run2_seg", seg, 7'h40);

    // load 3A: digit0=A, digit1=3
    load = 1'b1; digits = 8'h3A;
    step();
    load = 1'b0;
    step();
    check("ld_sum", sum, 13);
    check("ld_seg0", seg, 7'h08);
    check("ld_an0", anode, 2'b10);
    check("ld_wrap_tick", slot_tick, 1);
    step();
    check("d1_seg", seg, 7'h30);
    check("d1_an", anode, 2'b01);
    check("d1_tick", slot_tick, 0);

    // free run, 16 cycles
    for (int i = 0; i < 16; i++) begin
      step();
      exp_an  = (((i + 1) / 4) % 2 == 0) ? 2'b01 : 2'b10;
      exp_seg = (((i + 1) / 4) % 2 == 0) ? 7'h30 : 7'h08;
      check("fr_tick", slot_tick, (i % 4 == 2) ? 1 : 0);
      check("fr_an", anode, exp_an);
      check("fr_seg", seg, exp_seg);
    end

    // load FF, then load 00 on the wrap cycle
    load = 1'b1; digits = 8'hFF;
    step();
    load = 1'b0;
    step();
    check("ff_sum", sum, 30);
    step();
    check("ff_wrap_tick", slot_tick, 1);
    load = 1'b1; digits = 8'h00;
    step();
    load = 1'b0;
    check("wl_seg_old", seg, 7'h0E);
    check("wl_an", anode, 2'b10);
    check("wl_sum_old", sum, 30);
    step();
    check("wl_seg_new", seg, 7'h40);
    check("wl_sum_new", sum, 0);
    check("wl_an2", anode, 2'b10);

    // mid-slot reset at counter=2, idx=1
    load = 1'b1; digits = 8'h21;
    step();
    load = 1'b0;
    step(); step(); step();
    check("pre_an", anode, 2'b01);
    check("pre_seg", seg, 7'h24);
    check("pre_sum", sum, 3);
    reset = 1'b1;
    #2;
    check("mid_rst_seg", seg, 7'h7F);
    check("mid_rst_an", anode, 2'b11);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_tick", slot_tick, 0);
    step();
    reset = 1'b0;
    step();
    check("rs1_an", anode, 2'b11);
    step();
    check("rs2_an", anode, 2'b10);
    check("rs2_seg", seg, 7'h40);
    step(); step();
    check("rs4_tick", slot_tick, 1);
    check("rs4_an", anode, 2'b10);
    step();
    check("rs5_an", anode, 2'b01);

    // 3-digit sequencing, max sum, and blanking instance
    reset = 1'b1;
    load = 1'b1; digits = 8'h3A; digits3 = 12'hFFF;
    step(); step();
    reset = 1'b0;
    for (int e = 1; e <= 25; e++) begin
      step();
      if (e == 1) load = 1'b0;
      if (e == 2) begin
        check("n3_sum", sum3, 45);
        check("n2_sum", sum, 13);
      end
      if (e >= 2) begin
        d = ((e - 1) / 4) % 3;
        exp3 = 3'b001 << d;
        exp3 = ~exp3;
        check("n3_an", anode3, exp3);
      end
      if (e >= 2 && e <= 17) begin
        prev = (e - 1) % 4;
`ifdef BLANK_GAP_EN
        show = (prev >= 2);
`else
        show = 1'b1;
`endif
        d = ((e - 1) / 4) % 2;
        exp_an  = show ? ((d == 1) ? 2'b01 : 2'b10) : 2'b11;
        exp_seg = show ? ((d == 1) ? 7'h30 : 7'h08) : 7'h7F;
        check("blk_an", anode_b, exp_an);
        check("blk_seg", seg_b, exp_seg);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
